dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Multi-cycle data-memory responder that sits on the far side of the pipeline's MEM-stage memory interface.
- Accepts MemRead/MemWrite requests, holds the pipeline with stall_o while an access is in flight, performs the access after a programmable latency, and returns read data with a done/error pulse.
- Replaces the single-cycle data memory so that cache and slow-memory timing can be modelled.

Parameters:
DEPTH, 256, number of 32-bit words; word index = addr_i[31:2].
LATENCY, 4, busy cycles per access after acceptance; legal range 1..15 (4-bit counter).

Ports:
clk_i  input  1  clock; all state updates on the rising edge.
rst_i  input  1  asynchronous, active-low reset.
MemRead_i  input  1  read request from the EX/MEM stage.
MemWrite_i  input  1  write request from the EX/MEM stage.
addr_i  input  32  byte address; must be word aligned.
data_i  input  32  write data.
data_o  output  32  registered read data; holds the last completed read.
stall_o  output  1  freeze PC, IF/ID, ID/EX, EX/MEM and MEM/WB while high.
done_o  output  1  one-cycle pulse when an access completes.
err_o  output  1  one-cycle pulse, together with done_o, when the access was illegal.

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE, counter=0, data_o=0, done_o=0, err_o=0. Memory array is not cleared. Any in-flight access is discarded; a pending write is never committed.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req = MemRead_i | MemWrite_i.
  - stall_o = req, combinational in the same cycle.
  - On req: latch op, addr and data; counter=LATENCY-1; go to BUSY.
- BUSY:
  - stall_o=1.
  - Counter decrements each cycle.
  - At counter==0: perform the access and go to DONE.
  - Inputs are ignored in BUSY; only the latched copies are used.
- DONE:
  - stall_o=0, done_o=1.
  - Return to IDLE unconditionally. The request still present this cycle is the one just served and must not be re-accepted.
- Timing per access: stall_o high for LATENCY+1 cycles; the request is visible for LATENCY+2 cycles. A back-to-back access is accepted in the first IDLE cycle after DONE.
- Read: data_o <= mem[idx] on the BUSY->DONE edge. It is valid in DONE and held until the next completed read.
- Write: mem[idx] <= latched data on the BUSY->DONE edge. data_o is unchanged.
- Illegal access: addr[1:0]!=0, or idx>=DEPTH, or MemRead_i and MemWrite_i both high at acceptance.
  - No array write.
  - A read returns data_o=0.
  - err_o=1 in DONE. Timing is identical to a legal access.
- Output registers: done_o and err_o are registered. stall_o is combinational from state and the inputs.

Optional Feature:
- Macro: DMEM_POSTED_WRITE_EN.
- Defined:
  - Writes are posted into a one-entry write buffer (addr, data, valid).
  - In IDLE with the buffer empty, a legal write has stall_o=0 and done_o pulses the next cycle. The buffer then drains to the array after LATENCY cycles, in the background.
  - A write arriving while the buffer is valid stalls until the drain completes, then posts.
  - A read to the buffered address returns the buffered data (forwarding) with normal read latency.
  - Reads to other addresses proceed with normal latency; the drain continues in parallel.
  - Illegal writes are not posted and take the normal err path.
  - Reset clears the buffer valid bit.
- Undefined: all accesses behave as the blocking FSM above. No buffer logic is present.

Test Plan:
- Reset: hold rst_i=0 mid-operation with MemRead_i=1 -> data_o=0, stall_o=0, done_o=0, err_o=0; after release the FSM is in IDLE.
- LATENCY=4: write 0xDEADBEEF to 0x10, then read 0x10 -> each access stall_o=1 for 5 cycles, done_o in the 6th; read data_o=0xDEADBEEF, err_o=0.
- Misaligned read at 0x13 (previous data_o=0xDEADBEEF) -> done_o=1, err_o=1, data_o=0; mem unchanged.
- Write 0xCAFEF00D to 0x400 (idx 256 >= DEPTH) -> err_o=1; then read 0x0 returns its prior value 0x11111111.
- mem[0x20]=0x0; start write 0x12345678 to 0x20; pulse rst_i=0 in BUSY cycle 2 -> later read of 0x20 returns 0x0.
- DMEM_POSTED_WRITE_EN: write 0xA5A5A5A5 to 0x40 -> stall_o=0 that cycle; immediate read of 0x40 -> data_o=0xA5A5A5A5 after 5 stall cycles; a second write issued while the buffer is full stalls until the drain completes.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory with a programmable access latency.
// Define DMEM_POSTED_WRITE_EN to post legal writes into a one-entry background write buffer.
module dmem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        done_o,
    output logic        err_o
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;
    logic [3:0]    cnt;
    logic          lat_rd, lat_wr, lat_err;
    logic [AW-1:0] lat_idx;
    logic [31:0]   lat_data, rd_val;
    logic [31:0]   mem [DEPTH];
    logic          req, bad_now, accept, finish, post, hold_wr;
    assign req     = MemRead_i | MemWrite_i;
    assign bad_now = (addr_i[1:0] != 2'b00) || ({2'b00, addr_i[31:2]} >= 32'(DEPTH)) || (MemRead_i && MemWrite_i);
    assign accept  = state == IDLE && req && !post && !hold_wr;
    assign finish  = state == BUSY && cnt == 4'd0;
`ifdef DMEM_POSTED_WRITE_EN
    logic          wb_valid, wb_drain;
    logic [3:0]    wb_cnt;
    logic [AW-1:0] wb_idx;
    logic [31:0]   wb_data;
    // bad_now already excludes simultaneous read, so a legal write here is a pure write
    assign post     = state == IDLE && MemWrite_i && !bad_now && !wb_valid;
    assign hold_wr  = state == IDLE && MemWrite_i && !bad_now && wb_valid;
    assign wb_drain = wb_valid && wb_cnt == 4'd0;
    assign rd_val   = lat_err ? 32'h0 : (wb_valid && wb_idx == lat_idx) ? wb_data : mem[lat_idx];
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wb_valid <= 1'b0;
            wb_cnt   <= 4'd0;
            wb_idx   <= '0;
            wb_data  <= 32'h0;
        end else if (post) begin
            wb_valid <= 1'b1;
            wb_cnt   <= 4'(LATENCY - 1);
            wb_idx   <= addr_i[AW+1:2];
            wb_data  <= data_i;
        end else if (wb_drain) begin
            wb_valid <= 1'b0;
        end else if (wb_valid) begin
            wb_cnt   <= wb_cnt - 4'd1;
        end
    end
`else
    assign post    = 1'b0;
    assign hold_wr = 1'b0;
    assign rd_val  = lat_err ? 32'h0 : mem[lat_idx];
`endif
    always_comb begin
        state_nxt = state == IDLE ? (accept ? BUSY : IDLE) : state == BUSY ? (finish ? DONE : BUSY) : IDLE;
        stall_o   = rst_i && (state == BUSY || (state == IDLE && req && !post));
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            data_o   <= 32'h0;
            done_o   <= 1'b0;
            err_o    <= 1'b0;
            lat_rd   <= 1'b0;
            lat_wr   <= 1'b0;
            lat_err  <= 1'b0;
            lat_idx  <= '0;
            lat_data <= 32'h0;
        end else begin
            state  <= state_nxt;
            done_o <= finish || post;
            err_o  <= finish && lat_err;
            if (accept) begin
                lat_rd   <= MemRead_i;
                lat_wr   <= MemWrite_i;
                lat_err  <= bad_now;
                lat_idx  <= addr_i[AW+1:2];
                lat_data <= data_i;
                cnt      <= 4'(LATENCY - 1);
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (finish && lat_rd) data_o <= rd_val;
        end
    end
    // the array is never reset; only committed accesses touch it
    always_ff @(posedge clk_i) begin
        if (finish && lat_wr && !lat_err) mem[lat_idx] <= lat_data;
`ifdef DMEM_POSTED_WRITE_EN
        if (wb_drain) mem[wb_idx] <= wb_data;
`endif
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder (LATENCY=4, DEPTH=256).
module tb_dmem_responder;
    logic        clk_i = 1'b0, rst_i = 1'b0, MemRead_i = 1'b0, MemWrite_i = 1'b0;
    logic [31:0] addr_i = 32'h0, data_i = 32'h0;
    logic [31:0] data_o;
    logic        stall_o, done_o, err_o;
    int          errors = 0, checks = 0;

    dmem_responder #(.DEPTH(256), .LATENCY(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
        .addr_i(addr_i), .data_i(data_i), .data_o(data_o), .stall_o(stall_o),
        .done_o(done_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        MemRead_i = rd; MemWrite_i = wr; addr_i = a; data_i = d;
    endtask

    task automatic step;
        @(posedge clk_i); #1;
    endtask

    // Called at a negedge: counts stall cycles from here, checks the DONE cycle,
    // then drops the request and checks the request is not re-accepted.
    task automatic wait_done(input string tag, input int e_stall, input logic e_err,
                             input logic [31:0] e_data, input logic cd);
        int n = 0;
        while (stall_o === 1'b1 && n < 40) begin
            n++;
            @(negedge clk_i);
        end
        chk({tag, "_stall"}, n, e_stall);
        chk({tag, "_done"}, {31'b0, done_o}, 1);
        chk({tag, "_err"}, {31'b0, err_o}, {31'b0, e_err});
        if (cd) chk({tag, "_data"}, data_o, e_data);
        step();
        req(0, 0, 0, 0);
        @(negedge clk_i);
        chk({tag, "_idle"}, {30'b0, done_o, stall_o}, 0);
        step();
    endtask

    task automatic acc(input string tag, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic e_err, input logic [31:0] e_data, input logic cd);
        req(rd, wr, a, d);
        @(negedge clk_i);
        wait_done(tag, 5, e_err, e_data, cd);
    endtask

    initial begin
        req(1, 0, 32'h10, 0);
        @(negedge clk_i);
        chk("rst_data", data_o, 0);
        chk("rst_ctl", {29'b0, stall_o, done_o, err_o}, 0);
        step();
        rst_i = 1'b1;
        req(0, 0, 0, 0);
        @(negedge clk_i);
        chk("rst_rel_stall", {31'b0, stall_o}, 0);
        step();
`ifdef DMEM_POSTED_WRITE_EN
        acc("woob", 0, 1, 32'h400, 32'hCAFEF00D, 1, 32'h0, 1);
        req(0, 1, 32'h40, 32'hA5A5A5A5);
        @(negedge clk_i);
        chk("pw_stall", {31'b0, stall_o}, 0);
        step();
        req(1, 0, 32'h40, 0);
        @(negedge clk_i);
        chk("pw_done", {31'b0, done_o}, 1);
        wait_done("r40", 5, 0, 32'hA5A5A5A5, 1);
        req(0, 1, 32'h44, 32'h1);
        @(negedge clk_i);
        chk("pw1_stall", {31'b0, stall_o}, 0);
        step();
        req(0, 1, 32'h48, 32'h2);
        @(negedge clk_i);
        chk("pw1_done", {31'b0, done_o}, 1);
        begin
            int n = 0;
            while (stall_o === 1'b1 && n < 40) begin
                n++;
                @(negedge clk_i);
            end
            chk("pw2_wait", n, 4);
        end
        chk("pw2_done_low", {31'b0, done_o}, 0);
        step();
        req(0, 0, 0, 0);
        @(negedge clk_i);
        chk("pw2_done", {31'b0, done_o}, 1);
        step();
        acc("r48", 1, 0, 32'h48, 0, 0, 32'h2, 1);
        acc("r44", 1, 0, 32'h44, 0, 0, 32'h1, 1);
`else
        acc("w0", 0, 1, 32'h0, 32'h11111111, 0, 32'h0, 1);
        acc("w20", 0, 1, 32'h20, 32'h0, 0, 32'h0, 1);
        acc("w10", 0, 1, 32'h10, 32'hDEADBEEF, 0, 32'h0, 1);
        acc("r10", 1, 0, 32'h10, 0, 0, 32'hDEADBEEF, 1);
        acc("rmis", 1, 0, 32'h13, 0, 1, 32'h0, 1);
        acc("r10b", 1, 0, 32'h10, 0, 0, 32'hDEADBEEF, 1);
        acc("woob", 0, 1, 32'h400, 32'hCAFEF00D, 1, 32'hDEADBEEF, 1);
        acc("r0", 1, 0, 32'h0, 0, 0, 32'h11111111, 1);
        acc("both", 1, 1, 32'h0, 32'h99, 1, 32'h0, 0);
        acc("r0b", 1, 0, 32'h0, 0, 0, 32'h11111111, 1);
        req(1, 0, 32'h10, 0);
        step();
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rrd_data", data_o, 0);
        chk("rrd_ctl", {29'b0, stall_o, done_o, err_o}, 0);
        step();
        rst_i = 1'b1;
        req(0, 0, 0, 0);
        @(negedge clk_i);
        chk("rrd_idle", {31'b0, stall_o}, 0);
        step();
        acc("r10c", 1, 0, 32'h10, 0, 0, 32'hDEADBEEF, 1);
        req(0, 1, 32'h20, 32'h12345678);
        step();
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rwr_ctl", {29'b0, stall_o, done_o, err_o}, 0);
        chk("rwr_data", data_o, 0);
        step();
        rst_i = 1'b1;
        req(0, 0, 0, 0);
        step();
        acc("r20", 1, 0, 32'h20, 0, 0, 32'h0, 1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
